// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard/flush/halt sequencer for the 5-stage pipeline
//
// Decides each cycle whether PC and IF/ID advance, inserts ID/EX bubbles on
// data hazards, flushes the wrong path on EX redirects, selects EX operand
// forwarding and runs the halt-ecall drain sequence.
//
// Build option: HAZARD_FORWARDING_EN
//   defined   - forwarding mode: only load-use and WB matches stall, fwd_a/fwd_b live
//   undefined - full interlock: any EX/MEM/WB match stalls, fwd_a/fwd_b tied to 00
//
// Ports
//   clk, reset                        clock, async active-low reset
//   id_rs1/2, id_use_rs1/2            sources of the instruction in IF/ID
//   id_is_halt_ecall                  IF/ID holds a halting ecall
//   ex_rs1/2                          sources held in ID/EX (forwarding only)
//   ex_rd/ex_reg_write/ex_mem_read    ID/EX destination info
//   mem_rd/mem_reg_write              EX/MEM destination info
//   wb_rd/wb_reg_write                MEM/WB destination info
//   ex_redirect                       branch/jump redirect resolved in EX
//   pc_write, if_id_write             advance enables
//   if_id_flush, id_ex_bubble         NOP / zero-control injection
//   fwd_a, fwd_b                      00 ID/EX data, 01 EX/MEM alu_out, 10 WB rd_din
//   is_halted                         sticky halt flag
//   stall_count                       saturating count of hazard-stall cycles

module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_halt_ecall,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             is_halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic              is_halted_q, is_halted_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic rs1_hz, rs2_hz, hazard;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] rd,
                                     input logic we);
    return we && (rd != 5'd0) && (src == rd);
  endfunction

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time. The register file has no
  // write-through, so a WB producer still has to be waited out.
  assign rs1_hz = reg_match(id_rs1, ex_rd, ex_reg_write && ex_mem_read) ||
                  reg_match(id_rs1, wb_rd, wb_reg_write);
  assign rs2_hz = reg_match(id_rs2, ex_rd, ex_reg_write && ex_mem_read) ||
                  reg_match(id_rs2, wb_rd, wb_reg_write);

  // The younger producer (EX/MEM) holds the newer value and wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (reg_match(src, mem_rd, mem_reg_write))     return 2'b01;
    else if (reg_match(src, wb_rd, wb_reg_write))  return 2'b10;
    else                                           return 2'b00;
  endfunction

  assign fwd_a = reset ? fwd_sel(ex_rs1) : 2'b00;
  assign fwd_b = reset ? fwd_sel(ex_rs2) : 2'b00;
`else
  // Full interlock: the consumer waits until every older producer has retired.
  assign rs1_hz = reg_match(id_rs1, ex_rd, ex_reg_write) ||
                  reg_match(id_rs1, mem_rd, mem_reg_write) ||
                  reg_match(id_rs1, wb_rd, wb_reg_write);
  assign rs2_hz = reg_match(id_rs2, ex_rd, ex_reg_write) ||
                  reg_match(id_rs2, mem_rd, mem_reg_write) ||
                  reg_match(id_rs2, wb_rd, wb_reg_write);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;

  wire unused_fwd_inputs = &{1'b0, ex_rs1, ex_rs2, ex_mem_read};
`endif

  assign hazard = (id_use_rs1 && rs1_hz) || (id_use_rs2 && rs2_hz);

  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    is_halted_d   = is_halted_q;
    stall_count_d = stall_count_q;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_redirect) begin
          // Everything in IF/ID is wrong-path, including a halt ecall there.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
        end else if (hazard) begin
          id_ex_bubble = 1'b1;
          if (stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
        end else if (id_is_halt_ecall) begin
          // Freeze fetch; the ecall itself still moves into ID/EX.
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end

      ST_DRAIN: begin
        id_ex_bubble = 1'b1;
        drain_cnt_d  = drain_cnt_q + DW'(1);
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d     = ST_HALTED;
          drain_cnt_d = '0;
          is_halted_d = 1'b1;
        end
      end

      ST_HALTED: begin
        id_ex_bubble = 1'b1;
        is_halted_d  = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Hold the pipeline completely still while reset is asserted.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      drain_cnt_q   <= '0;
      is_halted_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      is_halted_q   <= is_halted_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign is_halted   = is_halted_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 4;
  localparam int CW    = 4;
  localparam int SMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, id_is_halt_ecall;
  logic          ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_redirect;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state: halted flag, cycles of drain still to go, stall total.
  bit m_halted;
  int m_drain_left;
  int m_stalls;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_halt_ecall(id_is_halt_ecall),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_redirect(ex_redirect),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .is_halted(is_halted), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit writes(input logic [4:0] s, input logic [4:0] rd, input bit we);
    return we && rd != 0 && s == rd;
  endfunction

  // Does source s have to wait, given what is in flight right now?
  function automatic bit must_wait(input logic [4:0] s);
`ifdef HAZARD_FORWARDING_EN
    return writes(s, ex_rd, ex_reg_write && ex_mem_read) || writes(s, wb_rd, wb_reg_write);
`else
    return writes(s, ex_rd, ex_reg_write) || writes(s, mem_rd, mem_reg_write) ||
           writes(s, wb_rd, wb_reg_write);
`endif
  endfunction

  function automatic logic [1:0] want_fwd(input logic [4:0] s);
`ifdef HAZARD_FORWARDING_EN
    if (writes(s, mem_rd, mem_reg_write)) return 2'b01;
    if (writes(s, wb_rd, wb_reg_write))   return 2'b10;
`endif
    return 2'b00;
  endfunction

  task automatic quiet();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, id_is_halt_ecall} = '0;
    {ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, ex_redirect} = '0;
  endtask

  function automatic logic [4:0] pick_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 5'd17 : 5'(r);
  endfunction

  task automatic randomize_inputs();
    reset            = ($urandom_range(0, 39) != 0);
    id_rs1           = pick_reg();
    id_rs2           = pick_reg();
    ex_rs1           = pick_reg();
    ex_rs2           = pick_reg();
    ex_rd            = pick_reg();
    mem_rd           = pick_reg();
    wb_rd            = pick_reg();
    id_use_rs1       = 1'($urandom_range(0, 1));
    id_use_rs2       = 1'($urandom_range(0, 1));
    ex_reg_write     = 1'($urandom_range(0, 1));
    ex_mem_read      = 1'($urandom_range(0, 1));
    mem_reg_write    = 1'($urandom_range(0, 1));
    wb_reg_write     = 1'($urandom_range(0, 1));
    ex_redirect      = ($urandom_range(0, 7) == 0);
    id_is_halt_ecall = ($urandom_range(0, 9) == 0);
  endtask

  // Inputs are already driven (at the falling edge). Predict, compare, then
  // advance the reference on the rising edge and return at the next falling edge.
  task automatic run_cycle();
    bit   e_pc, e_ifid, e_flush, e_bub;
    bit   n_halted;
    int   n_drain, n_stalls;
    logic [1:0] e_fa, e_fb;
    #1;
    if (!reset) begin
      m_halted = 0; m_drain_left = 0; m_stalls = 0;
    end
    {e_pc, e_ifid, e_flush, e_bub} = '0;
    e_fa = 2'b00; e_fb = 2'b00;
    n_halted = m_halted; n_drain = m_drain_left; n_stalls = m_stalls;
    if (reset) begin
      if (m_halted) begin
        e_bub = 1;
      end else if (m_drain_left > 0) begin
        e_bub = 1;
        n_drain = m_drain_left - 1;
        if (n_drain == 0) n_halted = 1;
      end else if (ex_redirect) begin
        {e_pc, e_ifid, e_flush, e_bub} = 4'b1111;
      end else if ((id_use_rs1 && must_wait(id_rs1)) || (id_use_rs2 && must_wait(id_rs2))) begin
        e_bub = 1;
        if (m_stalls < SMAX) n_stalls = m_stalls + 1;
      end else if (id_is_halt_ecall) begin
        n_drain = DRAIN;
      end else begin
        e_pc = 1; e_ifid = 1;
      end
      e_fa = want_fwd(ex_rs1);
      e_fb = want_fwd(ex_rs2);
    end
    check("pc_write",     32'(pc_write),     32'(e_pc));
    check("if_id_write",  32'(if_id_write),  32'(e_ifid));
    check("if_id_flush",  32'(if_id_flush),  32'(e_flush));
    check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
    check("fwd_a",        32'(fwd_a),        32'(e_fa));
    check("fwd_b",        32'(fwd_b),        32'(e_fb));
    check("is_halted",    32'(is_halted),    32'(m_halted));
    check("stall_count",  32'(stall_count),  32'(m_stalls));
    @(posedge clk);
    if (reset) begin
      m_halted = n_halted; m_drain_left = n_drain; m_stalls = n_stalls;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_halted = 0; m_drain_left = 0; m_stalls = 0;
    quiet();
    reset = 1'b0;
    @(negedge clk);
    run_cycle();
    run_cycle();

    // Release from reset with a quiet pipeline: fetch must advance at once.
    reset = 1'b1;
    run_cycle();

    // Load-use on x5, then the load moves to MEM and WB.
    ex_rd = 5'd5; ex_reg_write = 1; ex_mem_read = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
    run_cycle();
    ex_rd = 5'd0; ex_reg_write = 0; ex_mem_read = 0; mem_rd = 5'd5; mem_reg_write = 1;
    run_cycle();
    mem_rd = 5'd0; mem_reg_write = 0; wb_rd = 5'd5; wb_reg_write = 1; ex_rs1 = 5'd5;
    run_cycle();
    quiet();

    // ALU producer of x6 in EX, consumer in ID; then forward from MEM.
    ex_rd = 5'd6; ex_reg_write = 1; id_rs2 = 5'd6; id_use_rs2 = 1;
    run_cycle();
    quiet();
    ex_rs2 = 5'd6; mem_rd = 5'd6; mem_reg_write = 1;
    run_cycle();
    quiet();

    // Redirect beats both a hazard and a halt ecall in ID.
    ex_redirect = 1; id_is_halt_ecall = 1; id_rs1 = 5'd3; id_use_rs1 = 1;
    wb_rd = 5'd3; wb_reg_write = 1;
    run_cycle();
    quiet();
    run_cycle();

    // Full halt sequence, then hold for a while.
    id_is_halt_ecall = 1; id_rs1 = 5'd17; id_use_rs1 = 1;
    run_cycle();
    quiet();
    ex_redirect = 1;
    repeat (14) run_cycle();
    quiet();

    // Reset during drain: must come back in RUN and never flag halted.
    reset = 0; run_cycle();
    reset = 1;
    id_is_halt_ecall = 1; id_rs1 = 5'd17; id_use_rs1 = 1;
    run_cycle();
    quiet();
    repeat (2) run_cycle();
    reset = 0; run_cycle();
    reset = 1;
    repeat (6) run_cycle();

    // Stall long enough to hit counter saturation.
    wb_rd = 5'd3; wb_reg_write = 1; id_rs1 = 5'd3; id_use_rs1 = 1;
    repeat (20) run_cycle();
    quiet();
    run_cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
